avalon_button_pio: RTL and testbench

Parametrised Avalon-MM input PIO for the board's push-buttons and keys. It replaces the separate single-purpose button and key PIOs in the Pokemon SoC with one N-channel block. Each channel is synchronised, debounced and edge-captured, and a single masked interrupt goes to the Nios II. It also keeps a saturating press counter for accumulate-style game input, and drives the debounced levels straight to fabric logic.

---
 rtl/avalon_button_pio_if.sv | 25 ++
 rtl/avalon_button_pio.sv | 120 ++++++++++++
 tb/tb_avalon_button_pio.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_button_pio_if.sv
// avalon_button_pio_if: Avalon-MM slave bus bundle for the button PIO.
// Master drives address/strobes/data, slave returns registered read data.
interface avalon_button_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_button_pio.sv
// avalon_button_pio: N-channel synchronised, debounced, edge-captured button PIO.
// Define BTN_PIO_DEBOUNCE_EN to include the per-channel debounce counters.
module avalon_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset,
  avalon_button_pio_if.slave avs,
  output logic               irq,
  input  logic [WIDTH-1:0]   btn_in,
  output logic [WIDTH-1:0]   btn_state
);

  localparam logic [WIDTH-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] ec_clr;
  logic [15:0]      press_cnt;
  logic [31:0]      rd_mux;
  logic             wr_mask;
  logic             wr_ec;
  logic             wr_cnt;
  logic             unused_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= IDLE;
      sync_q <= IDLE;
    end else begin
      meta   <= btn_in;
      sync_q <= meta;
    end
  end

  assign sync = ACTIVE_LOW ? ~sync_q : sync_q;

`ifdef BTN_PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;

  // A level is accepted only after it differs from stable for CMAX+1 cycles
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CMAX) stable_nxt[i] = sync[i];
        else                cnt_nxt[i]    = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`else
  logic unused_db;

  assign unused_db  = ^DEBOUNCE_CYCLES;
  assign stable_nxt = sync;
`endif

  // stable is the delayed copy of stable_nxt, so events land with btn_state
  assign press = stable_nxt & ~stable;

  assign wr_mask = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_ec   = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_cnt  = avs.avs_write && (avs.avs_address == 2'd3);
  assign ec_clr  = wr_ec ? avs.avs_writedata[WIDTH-1:0] : '0;

  assign unused_wd = ^avs.avs_writedata;

  always_comb begin
    rd_mux = '0;
    unique case (avs.avs_address)
      2'd0: rd_mux[WIDTH-1:0] = stable;
      2'd1: rd_mux[WIDTH-1:0] = mask;
      2'd2: rd_mux[WIDTH-1:0] = edgecap;
      2'd3: rd_mux[15:0]      = press_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable           <= '0;
      mask             <= '0;
      edgecap          <= '0;
      press_cnt        <= '0;
      avs.avs_readdata <= '0;
    end else begin
      stable  <= stable_nxt;
      edgecap <= (edgecap & ~ec_clr) | press;
      if (wr_mask) mask <= avs.avs_writedata[WIDTH-1:0];
      if (|press) begin
        press_cnt <= wr_cnt ? 16'd1
                            : press_cnt + {15'd0, ~&press_cnt};
      end else if (wr_cnt) begin
        press_cnt <= '0;
      end
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

  assign btn_state = stable;
  assign irq       = |(edgecap & mask);

endmodule

// File: tb/tb_avalon_button_pio.sv
// tb_avalon_button_pio: directed checks of debounce, edge capture, irq,
// press counter saturation/clear and reset behaviour.
module tb_avalon_button_pio;

  localparam int DB = 4;
`ifdef BTN_PIO_DEBOUNCE_EN
  localparam bit DBEN = 1'b1;
`else
  localparam bit DBEN = 1'b0;
`endif
  localparam int LAT = DBEN ? DB + 2 : 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_in = 4'hF;
  logic [3:0] btn_state;
  logic       irq;
  logic [31:0] rdata;
  int n_cmp = 0;
  int n_bad = 0;

  avalon_button_pio_if bus ();

  avalon_button_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs(bus),
    .irq(irq),
    .btn_in(btn_in),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick(1);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick(1);
    bus.avs_write     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;

    // Reset state
    tick(3);
    check("rst_state", {28'd0, btn_state}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", bus.avs_readdata, 32'd0);
    reset = 1'b0;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], rdata);
      check("rst_reg", rdata, 32'd0);
    end

    // Single press on ch0
    btn_in[0] = 1'b0;
    tick(LAT - 1);
    check("t1_pre", {28'd0, btn_state}, 32'd0);
    tick(1);
    check("t1_state", {28'd0, btn_state}, 32'h1);
    check("t1_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, rdata); check("t1_data", rdata, 32'h1);
    rd(2'd2, rdata); check("t1_edge", rdata, 32'h1);
    rd(2'd3, rdata); check("t1_cnt", rdata, 32'h1);
    btn_in[0] = 1'b1;
    tick(LAT + 1);
    check("t1_rel", {28'd0, btn_state}, 32'd0);
    rd(2'd3, rdata); check("t1_relcnt", rdata, 32'h1);
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h0);
    rd(2'd2, rdata); check("t1_clr_edge", rdata, 32'h0);
    rd(2'd3, rdata); check("t1_clr_cnt", rdata, 32'h0);

    // Bouncing ch1
    btn_in[1] = 1'b0; tick(2);
    btn_in[1] = 1'b1; tick(2);
    btn_in[1] = 1'b0;
    tick(LAT - 1);
    check("t2_pre", {28'd0, btn_state}, 32'd0);
    tick(1);
    check("t2_state", {28'd0, btn_state}, 32'h2);
    rd(2'd3, rdata); check("t2_cnt", rdata, DBEN ? 32'd1 : 32'd2);
    rd(2'd2, rdata); check("t2_edge", rdata, 32'h2);
    btn_in[1] = 1'b1;
    tick(LAT + 1);
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h0);

    // Masked interrupt and clear/set collision
    wr(2'd1, 32'h2);
    rd(2'd1, rdata); check("t3_mask", rdata, 32'h2);
    check("t3_irq0", {31'd0, irq}, 32'd0);
    btn_in[1] = 1'b0;
    tick(LAT - 1);
    check("t3_irq_pre", {31'd0, irq}, 32'd0);
    tick(1);
    check("t3_irq1", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h2);
    check("t3_irq_clr", {31'd0, irq}, 32'd0);
    btn_in[1] = 1'b1;
    tick(LAT + 1);
    btn_in[1] = 1'b0;
    tick(LAT - 1);
    wr(2'd2, 32'h2);
    check("t3_irq_setwins", {31'd0, irq}, 32'd1);
    rd(2'd2, rdata); check("t3_edge_setwins", rdata, 32'h2);
    btn_in[1] = 1'b1;
    tick(LAT + 1);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h0);

    // Read and write of the same register on one edge
    wr(2'd1, 32'hA);
    bus.avs_address   = 2'd1;
    bus.avs_writedata = 32'h5;
    bus.avs_read      = 1'b1;
    bus.avs_write     = 1'b1;
    tick(1);
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    check("rw_old", bus.avs_readdata, 32'hA);
    tick(2);
    check("rd_hold", bus.avs_readdata, 32'hA);
    rd(2'd1, rdata); check("rw_new", rdata, 32'h5);
    wr(2'd1, 32'h0);

    // Simultaneous presses, saturation, write-clear collision
    btn_in = 4'b1010;
    tick(LAT + 1);
    rd(2'd2, rdata); check("t4_edge", rdata, 32'h5);
    rd(2'd3, rdata); check("t4_cnt", rdata, 32'h1);
    btn_in = 4'hF;
    tick(LAT + 1);
    force dut.press_cnt = 16'hFFFE;
    #1;
    release dut.press_cnt;
    rd(2'd3, rdata); check("t4_preload", rdata, 32'hFFFE);
    for (int p = 0; p < 3; p++) begin
      btn_in[3] = 1'b0; tick(LAT + 1);
      btn_in[3] = 1'b1; tick(LAT + 1);
    end
    rd(2'd3, rdata); check("t4_sat", rdata, 32'hFFFF);
    btn_in[3] = 1'b0;
    tick(LAT - 1);
    wr(2'd3, 32'h0);
    rd(2'd3, rdata); check("t4_wrpress", rdata, 32'h1);
    rd(2'd2, rdata); check("t4_edge2", rdata, 32'hD);

    // Reset in the middle of a debounce
    wr(2'd1, 32'hF);
    check("t5_irq_pre", {31'd0, irq}, 32'd1);
    btn_in[3] = 1'b1;
    tick(LAT + 1);
    rd(2'd2, rdata);
    btn_in[3] = 1'b0;
    tick(4);
    reset = 1'b1;
    #1;
    check("t5_rst_state", {28'd0, btn_state}, 32'd0);
    check("t5_rst_irq", {31'd0, irq}, 32'd0);
    check("t5_rst_rdata", bus.avs_readdata, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(LAT - 1);
    check("t5_pre", {28'd0, btn_state}, 32'd0);
    tick(1);
    check("t5_state", {28'd0, btn_state}, 32'h8);
    rd(2'd2, rdata); check("t5_edge", rdata, 32'h8);
    rd(2'd3, rdata); check("t5_cnt", rdata, 32'h1);
    check("t5_irq", {31'd0, irq}, 32'd0);

    // One-cycle glitch on ch2
    btn_in[3] = 1'b1;
    tick(LAT + 1);
    wr(2'd2, 32'hF);
    btn_in[2] = 1'b0;
    tick(1);
    btn_in[2] = 1'b1;
    tick(2);
    check("t6_pulse", {28'd0, btn_state}, DBEN ? 32'h0 : 32'h4);
    tick(1);
    check("t6_after", {28'd0, btn_state}, 32'h0);
    tick(LAT);
    rd(2'd2, rdata); check("t6_edge", rdata, DBEN ? 32'h0 : 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
